// File: rtl/sound_mixer.sv
// -----------------------------------------------------------------------------
// sound_mixer
//
// Final stage of the audio path. On each I_STROBE the four 20-bit channel
// waveforms and the NR50/NR51 settings are snapshotted, then mixed over a
// fixed sequence: four accumulate cycles (one channel each), one scale and
// saturate cycle, and one output cycle. O_LEFT_SAMPLE / O_RIGHT_SAMPLE are
// registered and O_SAMPLE_VALID pulses for one cycle when they update. The
// strobe-to-valid latency is six cycles.
//
// The block also owns the NR50 (master volume), NR51 (routing) and NR52
// (master enable / channel status) IO registers.
//
// Optional feature (macro SOUND_MIXER_CH_GATE_EN):
//   defined   - a channel whose ON flag was low at snapshot contributes 0.
//   undefined - ON flags only affect the NR52 readback.
//
// Ports:
//   I_CLK           system clock
//   I_RESET         asynchronous active-high reset
//   I_STROBE        one-cycle request for a new output sample
//   I_IOREG_ADDR    IO register address
//   IO_IOREG_DATA   IO register data, driven only during a matching read
//   I_IOREG_WE_L    write enable, active low
//   I_IOREG_RE_L    read enable, active low
//   I_CHn_WAVEFORM  signed channel samples (n = 1..4)
//   I_CHn_ON        channel active flags (n = 1..4)
//   O_LEFT_SAMPLE   signed mixed left sample (SO2)
//   O_RIGHT_SAMPLE  signed mixed right sample (SO1)
//   O_SAMPLE_VALID  one-cycle pulse when the output samples update
//   O_OVERRUN       sticky; a strobe arrived while a mix was in progress
// -----------------------------------------------------------------------------
module sound_mixer #(
    parameter logic [15:0] NR50_ADDR = 16'hFF24,
    parameter logic [15:0] NR51_ADDR = 16'hFF25,
    parameter logic [15:0] NR52_ADDR = 16'hFF26
) (
    input  logic        I_CLK,
    input  logic        I_RESET,
    input  logic        I_STROBE,
    input  logic [15:0] I_IOREG_ADDR,
    inout  wire logic [7:0] IO_IOREG_DATA,
    input  logic        I_IOREG_WE_L,
    input  logic        I_IOREG_RE_L,
    input  logic [19:0] I_CH1_WAVEFORM,
    input  logic [19:0] I_CH2_WAVEFORM,
    input  logic [19:0] I_CH3_WAVEFORM,
    input  logic [19:0] I_CH4_WAVEFORM,
    input  logic        I_CH1_ON,
    input  logic        I_CH2_ON,
    input  logic        I_CH3_ON,
    input  logic        I_CH4_ON,
    output logic [19:0] O_LEFT_SAMPLE,
    output logic [19:0] O_RIGHT_SAMPLE,
    output logic        O_SAMPLE_VALID,
    output logic        O_OVERRUN
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ACC   = 2'd1;
    localparam logic [1:0] ST_SCALE = 2'd2;
    localparam logic [1:0] ST_OUT   = 2'd3;

    // ------------------------------------------------------------------
    // IO registers
    // ------------------------------------------------------------------
    logic [7:0] nr50;
    logic [7:0] nr51;
    logic       nr52_en;
    logic [7:0] rd_data;
    logic       rd_hit;

    always_ff @(posedge I_CLK or posedge I_RESET) begin
        if (I_RESET) begin
            nr50    <= '0;
            nr51    <= '0;
            nr52_en <= 1'b0;
        end else if (!I_IOREG_WE_L) begin
            if (I_IOREG_ADDR == NR52_ADDR) begin
                nr52_en <= IO_IOREG_DATA[7];
                // Powering down wipes the volume and routing settings.
                if (!IO_IOREG_DATA[7]) begin
                    nr50 <= '0;
                    nr51 <= '0;
                end
            end else if (I_IOREG_ADDR == NR50_ADDR) begin
                if (nr52_en) nr50 <= IO_IOREG_DATA;
            end else if (I_IOREG_ADDR == NR51_ADDR) begin
                if (nr52_en) nr51 <= IO_IOREG_DATA;
            end
        end
    end

    always_comb begin
        rd_hit  = 1'b0;
        rd_data = '0;
        if (!I_IOREG_RE_L) begin
            if (I_IOREG_ADDR == NR50_ADDR) begin
                rd_hit  = 1'b1;
                rd_data = nr50;
            end else if (I_IOREG_ADDR == NR51_ADDR) begin
                rd_hit  = 1'b1;
                rd_data = nr51;
            end else if (I_IOREG_ADDR == NR52_ADDR) begin
                rd_hit  = 1'b1;
                rd_data = {nr52_en, 3'b111, I_CH4_ON, I_CH3_ON, I_CH2_ON, I_CH1_ON};
            end
        end
    end

    assign IO_IOREG_DATA = rd_hit ? rd_data : 'z;

    // ------------------------------------------------------------------
    // Mix datapath
    // ------------------------------------------------------------------
    logic [1:0]  state;
    logic [1:0]  idx;
    logic [19:0] snap_wave [4];
    logic [7:0]  snap_route;
    logic [2:0]  snap_vol_l;
    logic [2:0]  snap_vol_r;
    logic        snap_en;
`ifdef SOUND_MIXER_CH_GATE_EN
    logic [3:0]  snap_on;
`endif
    logic signed [21:0] acc_l;
    logic signed [21:0] acc_r;

    logic [19:0]        wave_sel;
    logic signed [21:0] contrib;
    logic signed [24:0] acc_l_ext;
    logic signed [24:0] acc_r_ext;
    logic signed [24:0] mul_l;
    logic signed [24:0] mul_r;
    logic signed [24:0] prod_l;
    logic signed [24:0] prod_r;
    logic signed [24:0] shift_l;
    logic signed [24:0] shift_r;
    logic [19:0]        sat_l;
    logic [19:0]        sat_r;

    function automatic logic [19:0] saturate(input logic signed [24:0] v);
        if (v > 25'sd524287)
            saturate = 20'h7FFFF;
        else if (v < -25'sd524288)
            saturate = 20'h80000;
        else
            saturate = v[19:0];
    endfunction

    always_comb begin
        wave_sel = snap_wave[idx];
        contrib  = {{2{wave_sel[19]}}, wave_sel};
`ifdef SOUND_MIXER_CH_GATE_EN
        if (!snap_on[idx]) contrib = '0;
`endif
    end

    always_comb begin
        acc_l_ext = {{3{acc_l[21]}}, acc_l};
        acc_r_ext = {{3{acc_r[21]}}, acc_r};
        // Volume 0..7 maps to a gain of 1..8 eighths.
        mul_l     = {22'd0, snap_vol_l} + 25'sd1;
        mul_r     = {22'd0, snap_vol_r} + 25'sd1;
        prod_l    = acc_l_ext * mul_l;
        prod_r    = acc_r_ext * mul_r;
        shift_l   = prod_l >>> 3;
        shift_r   = prod_r >>> 3;
        sat_l     = saturate(shift_l);
        sat_r     = saturate(shift_r);
    end

    // The output registers load on the edge leaving SCALE, so the new samples
    // and VALID are both visible for exactly the cycle spent in OUT.
    always_ff @(posedge I_CLK or posedge I_RESET) begin
        if (I_RESET) begin
            state          <= ST_IDLE;
            idx            <= '0;
            snap_wave[0]   <= '0;
            snap_wave[1]   <= '0;
            snap_wave[2]   <= '0;
            snap_wave[3]   <= '0;
            snap_route     <= '0;
            snap_vol_l     <= '0;
            snap_vol_r     <= '0;
            snap_en        <= 1'b0;
`ifdef SOUND_MIXER_CH_GATE_EN
            snap_on        <= '0;
`endif
            acc_l          <= '0;
            acc_r          <= '0;
            O_LEFT_SAMPLE  <= '0;
            O_RIGHT_SAMPLE <= '0;
            O_SAMPLE_VALID <= 1'b0;
            O_OVERRUN      <= 1'b0;
        end else begin
            O_SAMPLE_VALID <= 1'b0;
            if (I_STROBE && (state != ST_IDLE)) O_OVERRUN <= 1'b1;

            case (state)
                ST_IDLE: begin
                    if (I_STROBE) begin
                        snap_wave[0] <= I_CH1_WAVEFORM;
                        snap_wave[1] <= I_CH2_WAVEFORM;
                        snap_wave[2] <= I_CH3_WAVEFORM;
                        snap_wave[3] <= I_CH4_WAVEFORM;
                        snap_route   <= nr51;
                        snap_vol_l   <= nr50[6:4];
                        snap_vol_r   <= nr50[2:0];
                        snap_en      <= nr52_en;
`ifdef SOUND_MIXER_CH_GATE_EN
                        snap_on      <= {I_CH4_ON, I_CH3_ON, I_CH2_ON, I_CH1_ON};
`endif
                        acc_l        <= '0;
                        acc_r        <= '0;
                        idx          <= '0;
                        state        <= ST_ACC;
                    end
                end
                ST_ACC: begin
                    if (snap_route[{1'b1, idx}]) acc_l <= acc_l + contrib;
                    if (snap_route[{1'b0, idx}]) acc_r <= acc_r + contrib;
                    idx <= idx + 2'd1;
                    if (idx == 2'd3) state <= ST_SCALE;
                end
                ST_SCALE: begin
                    O_LEFT_SAMPLE  <= snap_en ? sat_l : '0;
                    O_RIGHT_SAMPLE <= snap_en ? sat_r : '0;
                    O_SAMPLE_VALID <= 1'b1;
                    state          <= ST_OUT;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sound_mixer.sv
// -----------------------------------------------------------------------------
// tb_sound_mixer
//
// Self-checking bench for sound_mixer: a table of directed mix vectors with
// hand-computed results, randomized vectors checked against an integer
// reference model, and directed sequences for register behaviour, overrun,
// power-down mid-mix and reset mid-mix.
// -----------------------------------------------------------------------------
module tb_sound_mixer;

    localparam logic [15:0] A50 = 16'hFF24;
    localparam logic [15:0] A51 = 16'hFF25;
    localparam logic [15:0] A52 = 16'hFF26;

    logic        clk;
    logic        rst;
    logic        strobe;
    logic [15:0] addr;
    wire  [7:0]  io_bus;
    logic [7:0]  tb_data;
    logic        tb_drv;
    logic        we_l;
    logic        re_l;
    logic [19:0] w1, w2, w3, w4;
    logic        on1, on2, on3, on4;
    logic [19:0] left, right;
    logic        valid;
    logic        overrun;

    assign io_bus = tb_drv ? tb_data : 'z;

    sound_mixer #(
        .NR50_ADDR(A50),
        .NR51_ADDR(A51),
        .NR52_ADDR(A52)
    ) dut (
        .I_CLK          (clk),
        .I_RESET        (rst),
        .I_STROBE       (strobe),
        .I_IOREG_ADDR   (addr),
        .IO_IOREG_DATA  (io_bus),
        .I_IOREG_WE_L   (we_l),
        .I_IOREG_RE_L   (re_l),
        .I_CH1_WAVEFORM (w1),
        .I_CH2_WAVEFORM (w2),
        .I_CH3_WAVEFORM (w3),
        .I_CH4_WAVEFORM (w4),
        .I_CH1_ON       (on1),
        .I_CH2_ON       (on2),
        .I_CH3_ON       (on3),
        .I_CH4_ON       (on4),
        .O_LEFT_SAMPLE  (left),
        .O_RIGHT_SAMPLE (right),
        .O_SAMPLE_VALID (valid),
        .O_OVERRUN      (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]       nr50;
        logic [7:0]       nr51;
        logic [3:0][19:0] w;
        logic [3:0]       on;
        logic [31:0]      exp_l;
        logic [31:0]      exp_r;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [7:0] n50, input logic [7:0] n51,
                                input int a, input int b, input int c, input int d,
                                input logic [3:0] on, input int el, input int er);
        vec_t v;
        v.nr50  = n50;
        v.nr51  = n51;
        v.w[0]  = 20'(a);
        v.w[1]  = 20'(b);
        v.w[2]  = 20'(c);
        v.w[3]  = 20'(d);
        v.on    = on;
        v.exp_l = el;
        v.exp_r = er;
        return v;
    endfunction

    function automatic int clamp(input int x);
        if (x > 524287) return 524287;
        if (x < -524288) return -524288;
        return x;
    endfunction

    // Reference: plain integer sum per side, gain (vol+1)/8 with floor, clamp.
    function automatic void model(input vec_t v, input bit en, output int l, output int r);
        int sl, sr, wi, ml, mr;
        sl = 0;
        sr = 0;
        for (int i = 0; i < 4; i++) begin
            wi = int'($signed(v.w[i]));
`ifdef SOUND_MIXER_CH_GATE_EN
            if (!v.on[i]) wi = 0;
`endif
            if (v.nr51[4 + i]) sl += wi;
            if (v.nr51[i])     sr += wi;
        end
        ml = int'(v.nr50[6:4]) + 1;
        mr = int'(v.nr50[2:0]) + 1;
        l = en ? clamp((sl * ml) >>> 3) : 0;
        r = en ? clamp((sr * mr) >>> 3) : 0;
    endfunction

    // Called just after a rising edge; consumes one edge.
    task automatic reg_write(input logic [15:0] a, input logic [7:0] d);
        addr    = a;
        tb_data = d;
        tb_drv  = 1'b1;
        we_l    = 1'b0;
        @(posedge clk);
        #1;
        we_l    = 1'b1;
        tb_drv  = 1'b0;
    endtask

    task automatic reg_read(input logic [15:0] a, output logic [7:0] d);
        addr = a;
        re_l = 1'b0;
        #1;
        d    = io_bus;
        re_l = 1'b1;
        #1;
    endtask

    task automatic apply_inputs(input vec_t v);
        w1 = v.w[0]; w2 = v.w[1]; w3 = v.w[2]; w4 = v.w[3];
        {on4, on3, on2, on1} = v.on;
    endtask

    // Raises the strobe for one cycle; returns with one edge consumed.
    task automatic pulse_strobe();
        strobe = 1'b1;
        @(posedge clk);
        #1;
        strobe = 1'b0;
    endtask

    // Wait for VALID; 'cyc' counts edges since the strobe was raised.
    task automatic wait_valid(input int start, output int cyc);
        cyc = start;
        while (!valid && cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic mix_check(input string name, input int el, input int er);
        int cyc;
        pulse_strobe();
        wait_valid(1, cyc);
        chk({name, " latency"}, cyc, 6);
        chk({name, " left"}, int'($signed(left)), el);
        chk({name, " right"}, int'($signed(right)), er);
        @(posedge clk);
        #1;
        chk({name, " valid width"}, int'(valid), 0);
    endtask

    task automatic program_mix(input vec_t v);
        reg_write(A52, 8'h80);
        reg_write(A50, v.nr50);
        reg_write(A51, v.nr51);
        apply_inputs(v);
    endtask

    vec_t       vecs [8];
    vec_t       rv;
    logic [7:0] d;
    int         el, er, cyc, nvalid, first;

    initial begin
        rst = 1'b1; strobe = 1'b0; addr = '0; tb_data = '0; tb_drv = 1'b0;
        we_l = 1'b1; re_l = 1'b1;
        w1 = '0; w2 = '0; w3 = '0; w4 = '0;
        on1 = 1'b0; on2 = 1'b0; on3 = 1'b0; on4 = 1'b0;

        vecs[0] = mk(8'h77, 8'hFF, 1000, 1000, 1000, 1000, 4'hF, 4000, 4000);
        vecs[1] = mk(8'h30, 8'h21, 8000, -2000, 0, 0, 4'hF, -1000, 1000);
        vecs[2] = mk(8'h30, 8'h12, 8000, -2000, 0, 0, 4'hF, 4000, -250);
        vecs[3] = mk(8'h77, 8'hFF, 524287, 524287, 524287, 524287, 4'hF, 524287, 524287);
        vecs[4] = mk(8'h77, 8'hFF, -524288, -524288, -524288, -524288, 4'hF, -524288, -524288);
`ifdef SOUND_MIXER_CH_GATE_EN
        vecs[5] = mk(8'h77, 8'h44, 0, 0, 5000, 0, 4'b1011, 0, 0);
`else
        vecs[5] = mk(8'h77, 8'h44, 0, 0, 5000, 0, 4'b1011, 5000, 5000);
`endif
        vecs[6] = mk(8'h00, 8'h11, -1, 0, 0, 0, 4'hF, -1, -1);
        vecs[7] = mk(8'h70, 8'hF0, 131072, 131072, 131072, 131072, 4'hF, 524287, 0);

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        chk("reset left", int'(left), 0);
        chk("reset right", int'(right), 0);
        chk("reset valid", int'(valid), 0);
        chk("reset overrun", int'(overrun), 0);
        reg_read(A50, d); chk("reset nr50", int'(d), 8'h00);
        reg_read(A51, d); chk("reset nr51", int'(d), 8'h00);
        reg_read(A52, d); chk("reset nr52", int'(d), 8'h70);
        @(posedge clk); #1;
        mix_check("reset mix", 0, 0);

        // Writes ignored while powered down
        reg_write(A50, 8'h55);
        reg_write(A51, 8'hAA);
        reg_read(A50, d); chk("off nr50 write", int'(d), 8'h00);
        reg_read(A51, d); chk("off nr51 write", int'(d), 8'h00);

        // Register readback while powered
        reg_write(A52, 8'hFF);
        reg_write(A50, 8'h5A);
        reg_write(A51, 8'hC3);
        {on4, on3, on2, on1} = 4'b1010;
        reg_read(A52, d); chk("nr52 status", int'(d), 8'hFA);
        reg_read(A50, d); chk("nr50 readback", int'(d), 8'h5A);
        reg_read(A51, d); chk("nr51 readback", int'(d), 8'hC3);
        @(posedge clk); #1;

        // Directed table
        for (int i = 0; i < 8; i++) begin
            program_mix(vecs[i]);
            mix_check($sformatf("vec%0d", i), int'($signed(vecs[i].exp_l)),
                      int'($signed(vecs[i].exp_r)));
        end

        // Randomized against the model
        for (int i = 0; i < 30; i++) begin
            rv.nr50 = 8'($urandom);
            rv.nr51 = 8'($urandom);
            for (int k = 0; k < 4; k++) rv.w[k] = 20'($urandom);
            rv.on = 4'($urandom);
            model(rv, 1'b1, el, er);
            program_mix(rv);
            mix_check($sformatf("rand%0d", i), el, er);
        end
        chk("no overrun yet", int'(overrun), 0);

        // Overrun: second strobe two cycles after the first
        program_mix(vecs[0]);
        strobe = 1'b1;
        @(posedge clk); #1;          // edge 1
        strobe = 1'b0;
        @(posedge clk); #1;          // edge 2
        strobe = 1'b1;
        @(posedge clk); #1;          // edge 3
        strobe = 1'b0;
        nvalid = 0;
        first  = 0;
        for (int k = 3; k <= 15; k++) begin
            if (valid) begin
                nvalid++;
                if (first == 0) first = k;
            end
            if (k < 15) begin
                @(posedge clk); #1;
            end
        end
        chk("overrun valid count", nvalid, 1);
        chk("overrun latency", first, 6);
        chk("overrun left", int'($signed(left)), 4000);
        chk("overrun flag", int'(overrun), 1);
        mix_check("after overrun", 4000, 4000);
        chk("overrun sticky", int'(overrun), 1);

        // Power down mid-mix: current mix unaffected, settings cleared
        program_mix(vecs[0]);
        pulse_strobe();
        reg_write(A52, 8'h00);
        wait_valid(2, cyc);
        chk("pd latency", cyc, 6);
        chk("pd left", int'($signed(left)), 4000);
        chk("pd right", int'($signed(right)), 4000);
        @(posedge clk); #1;
        reg_read(A50, d); chk("pd nr50", int'(d), 8'h00);
        reg_read(A51, d); chk("pd nr51", int'(d), 8'h00);
        mix_check("pd next mix", 0, 0);

        // Reset mid-mix
        program_mix(vecs[0]);
        mix_check("pre-reset mix", 4000, 4000);
        pulse_strobe();
        @(posedge clk); #1;
        rst = 1'b1;
        #2;
        chk("midreset left", int'(left), 0);
        chk("midreset right", int'(right), 0);
        chk("midreset overrun", int'(overrun), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        nvalid = 0;
        for (int k = 0; k < 10; k++) begin
            if (valid) nvalid++;
            @(posedge clk); #1;
        end
        chk("midreset no valid", nvalid, 0);
        mix_check("post-reset mix", 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
